// File: rtl/fb_clear_writer.sv
// Clears the framebuffer to CLEAR_COLOR from the free-running coordinate stream, aligned to (0,0).
// Latency 2 cycles from pair presented to write; no backpressure, one write per cycle.
module fb_clear_writer #(
  parameter int                 WIDTH       = 240,
  parameter int                 HEIGHT      = 480,
  parameter int                 COORD_W     = 11,
  parameter int                 ADDR_W      = 17,
  parameter int                 DATA_W      = 8,
  parameter logic [DATA_W-1:0]  CLEAR_COLOR = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(HEIGHT);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0]  ROW   = ADDR_W'(WIDTH);
  localparam logic [ADDR_W:0]    TOTAL = (ADDR_W+1)'(WIDTH * HEIGHT);

  logic [2:0]         state, state_nxt;
  logic [ADDR_W:0]    count;
  logic               in_range, at_origin, at_last, accept;
  logic               s1_vld;
  logic [COORD_W-1:0] s1_x;
  logic [ADDR_W-1:0]  s1_row;

  assign in_range  = (x_coord < X_LIM) && (y_coord < Y_LIM);
  assign at_origin = (x_coord == '0) && (y_coord == '0);
  assign at_last   = (x_coord == X_MAX) && (y_coord == Y_MAX);

  // abort takes effect in the same cycle it is seen: that pair is dropped
  always_comb begin
    accept = 1'b0;
    case (state)
      S_ARMED: accept = !abort && at_origin;
      S_CLEAR: accept = !abort && in_range;
      default: accept = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_ARMED;
      S_ARMED:  if (abort) state_nxt = S_FLUSH;
                else if (at_origin) state_nxt = S_CLEAR;
      S_CLEAR:  if (abort) state_nxt = S_FLUSH;
                else if (accept && at_last) state_nxt = S_FLUSH;
      // stage 1 empty means the last write is on the port this cycle
      S_FLUSH:  if (!s1_vld) state_nxt = (count == TOTAL) ? S_FINISH : S_IDLE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start && !abort)
        count <= '0;
      else if (accept)
        count <= count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_vld  <= 1'b0;
      s1_x    <= '0;
      s1_row  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= CLEAR_COLOR;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_x   <= x_coord;
        s1_row <= ADDR_W'(y_coord) * ROW;
      end
      wr_en   <= s1_vld;
      wr_data <= CLEAR_COLOR;
      if (s1_vld)
        wr_addr <= s1_row + ADDR_W'(s1_x);
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

endmodule

// File: tb/tb_fb_clear_writer.sv
// Scoreboard bench for fb_clear_writer on a reduced geometry with a free-running coordinate source
// whose lines and frame extend past the active area.
module tb_fb_clear_writer;

  localparam int W     = 24;
  localparam int H     = 16;
  localparam int CW    = 11;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam logic [DW-1:0] COLOR = 8'hA5;
  localparam int GX    = W + 4;
  localparam int GY    = H + 5;
  localparam int FRAME = GX * GY;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] x_coord, y_coord;
  logic          busy, done, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  typedef struct { int cyc; int addr; } wr_t;
  wr_t exp_q[$];

  int cyc       = 0;
  int exp_done  = -1;
  int checks    = 0;
  int errors    = 0;
  int wr_total  = 0;
  int done_total = 0;
  int last_addr = -1;

  fb_clear_writer #(
    .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW), .CLEAR_COLOR(COLOR)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .x_coord(x_coord), .y_coord(y_coord),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // coordinate source: pair presented during cycle c is a pure function of c
  initial begin
    x_coord = '0;
    y_coord = '0;
    forever begin
      @(posedge clock);
      #1;
      x_coord = CW'((cyc % FRAME) % GX);
      y_coord = CW'((cyc % FRAME) / GX);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a write or done
  always @(negedge clock) begin
    wr_t e;
    if (wr_en) begin
      wr_total++;
      last_addr = int'(wr_addr);
      if (exp_q.size() == 0) begin
        check("spurious_write_addr", int'(wr_addr), -1);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", cyc, e.cyc);
        check("write_addr", int'(wr_addr), e.addr);
        check("write_data", int'(wr_data), int'(COLOR));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("missing_write_addr", -1, e.addr);
    end
    if (done) begin
      done_total++;
      check("done_cycle", cyc, exp_done);
      exp_done = -1;
    end else if (exp_done >= 0 && exp_done <= cyc) begin
      check("done_level", int'(done), 1);
      exp_done = -1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  // abort_off / poke_off / reset_off are cycle offsets from the aligned (0,0) cycle; -1 disables
  task automatic run_clear(input int abort_off, input int poke_off, input int reset_off,
                           input int exp_writes);
    int s, t0, t_last, ta, tend, g, w0, d0;
    wr_t e;
    s      = cyc;
    w0     = wr_total;
    d0     = done_total;
    t0     = (s / FRAME + 1) * FRAME;
    t_last = t0 + (H - 1) * GX + (W - 1);
    ta     = (abort_off >= 0) ? t0 + abort_off : -1;
    tend   = (ta >= 0) ? ta - 1 : t_last;
    for (int c = t0; c <= tend; c++) begin
      g = c - t0;
      if ((g % GX) < W && (g / GX) < H) begin
        e.cyc  = c + 2;
        e.addr = (g / GX) * W + (g % GX);
        exp_q.push_back(e);
      end
    end
    exp_done = (ta >= 0 || reset_off >= 0) ? -1 : t_last + 3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (poke_off >= 0) begin
      goto(t0 + poke_off);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    if (reset_off >= 0) begin
      goto(t0 + reset_off);
      #1;
      check("wr_en_before_reset", int'(wr_en), 1);
      reset = 1'b0;
      #1;
      check("wr_en_in_reset", int'(wr_en), 0);
      check("busy_in_reset", int'(busy), 0);
      exp_q.delete();
      exp_done = -1;
      step();
      check("busy_held_reset", int'(busy), 0);
      #1;
      reset = 1'b1;
      step();
      step();
      check("done_after_reset", done_total - d0, 0);
      return;
    end
    if (ta >= 0) begin
      goto(ta);
      abort = 1'b1;
      step();
      abort = 1'b0;
      goto(ta + 3);
      check("busy_after_abort", int'(busy), 0);
    end else begin
      goto(t_last + 3);
      check("busy_in_finish", int'(busy), 1);
      step();
      check("busy_after_done", int'(busy), 0);
    end
    step();
    check("writes_outstanding", exp_q.size(), 0);
    check("write_count", wr_total - w0, exp_writes);
    check("done_pulses", done_total - d0, (ta >= 0) ? 0 : 1);
    if (exp_writes > 0) check("last_addr", last_addr, exp_writes - 1);
  endtask

  initial begin
    int ax, ay, tgt;
    // reset held with start asserted
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_busy", int'(busy), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_done", int'(done), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), int'(COLOR));
    end
    start = 1'b0;
    #1;
    reset = 1'b1;
    step();

    // alignment: start while the source presents (17,3)
    tgt = (cyc / FRAME + 1) * FRAME + 3 * GX + 17;
    goto(tgt);
    check("align_x", int'(x_coord), 17);
    run_clear(-1, -1, -1, W * H);

    // random idle gap, full clear with a stray start mid-clear
    repeat ($urandom_range(1, FRAME)) step();
    run_clear(-1, $urandom_range(5, (H - 2) * GX), -1, W * H);

    // abort when (10,2) is presented
    run_clear(2 * GX + 10, -1, -1, 2 * W + 10);

    // random abort points inside the active area
    for (int k = 0; k < 3; k++) begin
      ay = $urandom_range(0, H - 1);
      ax = $urandom_range(0, W - 1);
      repeat ($urandom_range(1, 40)) step();
      run_clear(ay * GX + ax, -1, -1, ay * W + ax);
    end

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    repeat (FRAME + 5) step();
    check("start_abort_idle", int'(busy), 0);

    // asynchronous reset mid-clear, then a clean full clear
    run_clear(-1, -1, 10 * GX + 5, 0);
    repeat ($urandom_range(1, 50)) step();
    run_clear(-1, -1, -1, W * H);

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_clear_writer.md
Name: fb_clear_writer

Overview:
- Downstream consumer of the free-running clear-coordinate generator, which emits x_coord 0..239 and y_coord 0..524, one pair per clock.
- On a start request, aligns to the generator's (0,0) point and turns each in-range coordinate pair into one framebuffer write of CLEAR_COLOR at linear address y*WIDTH+x.
- Writes exactly WIDTH*HEIGHT pixels, then signals done.
- Sits between the coordinate generator and the framebuffer write port.

Parameters:
WIDTH, 240, active pixels per line; x_coord values >= WIDTH are skipped
HEIGHT, 480, active lines; y_coord values >= HEIGHT are skipped
COORD_W, 11, width of the coordinate inputs
ADDR_W, 17, framebuffer address width; must satisfy WIDTH*HEIGHT <= 2^ADDR_W
DATA_W, 8, pixel width
CLEAR_COLOR, 0, value written to every pixel

Ports:
clock  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a clear; honoured only in IDLE
abort  in  1  stop the clear early; no done pulse is produced
x_coord  in  COORD_W  column from the coordinate generator
y_coord  in  COORD_W  line from the coordinate generator
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last write of a completed clear
wr_en  out  1  framebuffer write strobe
wr_addr  out  ADDR_W  framebuffer write address
wr_data  out  DATA_W  framebuffer write data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, wr_en = 0; wr_addr = 0; wr_data = CLEAR_COLOR; pipeline valid bits cleared.
- Reset mid-clear discards any in-flight writes immediately. No done pulse.
- States: IDLE, ARMED, CLEAR, FLUSH, FINISH.
- IDLE:
  - start=1 and abort=0 -> ARMED.
  - start and abort high together -> abort wins; stay IDLE.
- ARMED:
  - Wait for x_coord=0 and y_coord=0.
  - That same cycle -> CLEAR, and the (0,0) pair is accepted as the first pixel.
- CLEAR:
  - Each cycle, accept the input pair if x_coord<WIDTH and y_coord<HEIGHT; otherwise take no action.
  - Accepting (WIDTH-1, HEIGHT-1) -> FLUSH.
- FLUSH: wait until the pipeline is empty (2 cycles), then -> FINISH.
- FINISH: done=1 for exactly one cycle, then -> IDLE.
- abort=1 in ARMED or CLEAR:
  - No further pairs are accepted from that cycle on.
  - Go to FLUSH; already-accepted writes complete.
  - After FLUSH, go directly to IDLE without the done pulse.
- abort is ignored in IDLE, FLUSH and FINISH.
- start is ignored whenever busy=1.
- Pipeline, 2 stages, latency 2:
  - Stage 1 registers valid, x, and the product y*WIDTH (ADDR_W bits, no truncation given the parameter constraint).
  - Stage 2 registers wr_addr = product + x, wr_en = valid, wr_data = CLEAR_COLOR.
  - A pair accepted at edge N appears on wr_en/wr_addr after edge N+2.
- Write port: the framebuffer accepts one write per cycle, so there is no backpressure. wr_en is high for exactly one cycle per accepted pixel.
- Accounting:
  - Accepted pairs are counted in an ADDR_W+1 bit counter.
  - A completed clear produces exactly WIDTH*HEIGHT writes covering addresses 0..WIDTH*HEIGHT-1, each written once.
- Wrap: the generator's line wrap (x 239->0) and frame wrap (y 524->0) need no special handling. Lines 480..524 are skipped by the range check.
- done and busy: done is asserted only in FINISH. busy stays 1 during FINISH and drops to 0 the cycle after.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> busy=0, wr_en=0, done=0, wr_addr=0 throughout.
- Alignment: start while generator at (17,3) -> no wr_en until generator reaches (0,0). First write is wr_addr=0, wr_data=0, 2 cycles after (0,0) is presented.
- Full clear with default parameters:
  - wr_en count = 115200.
  - Addresses are strictly increasing 0..115199 with no gaps.
  - First write of line 1 is wr_addr=240.
  - Lines 480..524 produce no writes.
  - done pulses exactly once, 3 cycles after (239,479) is presented.
  - busy falls the following cycle.
- Abort: abort at the cycle (100,2) is presented -> last write is wr_addr=579 (coordinate (99,2)), no done pulse, busy=0 within 3 cycles, scoreboard shows 580 writes.
- Start ignored and simultaneous start/abort:
  - start pulsed mid-clear -> write count and sequence unchanged.
  - In IDLE, start=1 and abort=1 together -> stays IDLE, busy=0.
- Reset mid-operation: assert reset at address ~5000 -> wr_en=0 and busy=0 asynchronously, no done. A new start afterwards produces a full clean 115200-write clear.
